// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: read-tracking FSM
// states, write-enable encodings and the starvation counter width.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD_I = 2'b01,
        RD_D = 2'b10
    } arb_state_e;

    localparam logic [1:0] WE_RD   = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b11;
    localparam int         WAIT_W  = 4;

    // Saturating increment for the starvation counter.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v == {WAIT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter in front of a single-port synchronous SRAM.
// Optional macro ARB_STARVE_EN adds a forced instruction grant after MAX_WAIT losses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [15:0]   i_rdata,
    input  logic          d_req,
    input  logic [1:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [15:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [15:0]   d_rdata,
    output logic          m_en,
    output logic [1:0]    m_we,
    output logic [AW-1:0] m_addr,
    output logic [15:0]   m_wdata,
    input  logic [15:0]   m_rdata
);

    if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
        $error("mem_arbiter: MAX_WAIT must be in 1..15");
    end

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic       force_i_s;
    logic       i_gnt_s;
    logic       d_gnt_s;

`ifdef ARB_STARVE_EN
    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_nxt_s;

    // Instruction port is forced through once it has lost MAX_WAIT cycles in a row.
    always_comb begin
        if (i_req && (wait_cnt_r == MAX_WAIT_C)) begin
            force_i_s = 1'b1;
        end else begin
            force_i_s = 1'b0;
        end
    end

    // Count consecutive instruction losses; any grant or withdrawal restarts the count.
    always_comb begin
        if (!i_req || i_gnt_s) begin
            wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end else begin
            wait_cnt_nxt_s = sat_inc(wait_cnt_r);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end
`else
    // Strict data-over-instruction priority: no forced instruction grant.
    always_comb begin
        force_i_s = 1'b0;
    end
`endif

    // Grant decision; held at zero while reset is asserted since requests may still be high.
    always_comb begin
        i_gnt_s = 1'b0;
        d_gnt_s = 1'b0;
        if (!rst) begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end else if (force_i_s) begin
            i_gnt_s = 1'b1;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // Route the winning request onto the SRAM port in the same cycle.
    always_comb begin
        m_en    = 1'b0;
        m_we    = WE_RD;
        m_addr  = {AW{1'b0}};
        m_wdata = 16'h0000;
        case ({i_gnt_s, d_gnt_s})
            2'b10: begin
                m_en   = 1'b1;
                m_we   = WE_RD;
                m_addr = i_addr;
            end
            2'b01: begin
                m_en    = 1'b1;
                m_we    = d_we;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end
            default: begin
                m_en    = 1'b0;
                m_we    = WE_RD;
                m_addr  = {AW{1'b0}};
                m_wdata = 16'h0000;
            end
        endcase
    end

    assign i_gnt = i_gnt_s;
    assign d_gnt = d_gnt_s;

    // Remember which port owns the read data arriving next cycle; writes leave nothing in flight.
    always_comb begin
        if (i_gnt_s) begin
            state_nxt_s = RD_I;
        end else if (d_gnt_s && (d_we == WE_RD)) begin
            state_nxt_s = RD_D;
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // In-flight read tracker; async reset drops any pending rvalid immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Return path: steer SRAM data to the owning port, zero otherwise.
    always_comb begin
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = 16'h0000;
        d_rdata  = 16'h0000;
        case (state_r)
            RD_I: begin
                i_rvalid = 1'b1;
                i_rdata  = m_rdata;
            end
            RD_D: begin
                d_rvalid = 1'b1;
                d_rdata  = m_rdata;
            end
            default: begin
                i_rvalid = 1'b0;
                d_rvalid = 1'b0;
                i_rdata  = 16'h0000;
                d_rdata  = 16'h0000;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed vectors push expected grants and
// read returns into a queue; a negedge monitor pops and compares them.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int AW = 16;
    localparam int K_IRV = 0;
    localparam int K_DRV = 1;
    localparam int K_IG  = 2;
    localparam int K_DG  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [15:0]   i_rdata;
    logic          d_req;
    logic [1:0]    d_we;
    logic [AW-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [15:0]   d_rdata;
    logic          m_en;
    logic [1:0]    m_we;
    logic [AW-1:0] m_addr;
    logic [15:0]   m_wdata;
    logic [15:0]   m_rdata;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] addr;
        logic [1:0]  we;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  cyc_cnt = 0;
    int  errors  = 0;
    int  checks  = 0;
    logic prev_i = 1'b0;
    logic prev_d = 1'b0;

    mem_arbiter #(.AW(AW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    function automatic void push(input int k, input logic [15:0] a, input logic [1:0] w,
                                 input logic [15:0] d);
        ev_t e;
        e.cyc = cyc_cnt; e.kind = k; e.addr = a; e.we = w; e.data = d;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input int k, input logic [15:0] a, input logic [1:0] w,
                            input logic [15:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ev cyc=%0d: got kind=%0d addr=%h we=%b data=%h, required none",
                     cyc_cnt, k, a, w, d);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc_cnt || e.kind != k || e.addr != a || e.we != w || e.data != d) begin
                errors++;
                $display("FAIL event cyc=%0d: got kind=%0d addr=%h we=%b data=%h, required cyc=%0d kind=%0d addr=%h we=%b data=%h",
                         cyc_cnt, k, a, w, d, e.cyc, e.kind, e.addr, e.we, e.data);
            end
        end
    endtask

    // Monitor: compare whatever the DUT presents this cycle against the scoreboard.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc_cnt) begin
            checks++;
            errors++;
            $display("FAIL missing_ev: got nothing at cyc=%0d, required kind=%0d data=%h",
                     exp_q[0].cyc, exp_q[0].kind, exp_q[0].data);
            void'(exp_q.pop_front());
        end
        if (i_rvalid) check_ev(K_IRV, 16'h0000, 2'b00, i_rdata);
        if (d_rvalid) check_ev(K_DRV, 16'h0000, 2'b00, d_rdata);
        if (i_gnt)    check_ev(K_IG,  m_addr, m_we, m_wdata);
        if (d_gnt)    check_ev(K_DG,  m_addr, m_we, m_wdata);
        checks++;
        if (i_gnt || d_gnt) begin
            if (!m_en || (i_gnt && d_gnt)) begin
                errors++;
                $display("FAIL grant_port cyc=%0d: got m_en=%b i_gnt=%b d_gnt=%b, required m_en=1 single grant",
                         cyc_cnt, m_en, i_gnt, d_gnt);
            end
        end else if (m_en || m_we != 2'b00 || m_addr != 16'h0000 || m_wdata != 16'h0000) begin
            errors++;
            $display("FAIL idle_port cyc=%0d: got m_en=%b m_we=%b m_addr=%h m_wdata=%h, required all 0",
                     cyc_cnt, m_en, m_we, m_addr, m_wdata);
        end
        checks++;
        if ((!i_rvalid && i_rdata != 16'h0000) || (!d_rvalid && d_rdata != 16'h0000)) begin
            errors++;
            $display("FAIL rdata_zero cyc=%0d: got i_rdata=%h d_rdata=%h, required 0 when not valid",
                     cyc_cnt, i_rdata, d_rdata);
        end
    end

    // One cycle of stimulus with hand-given expected grants; read returns follow by one cycle.
    task automatic step(input logic ir, input logic [15:0] ia, input logic dr,
                        input logic [1:0] dwe, input logic [15:0] da, input logic [15:0] dwd,
                        input logic [15:0] rd, input logic eig, input logic edg);
        @(posedge clk);
        #1;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        m_rdata = rd;
        if (prev_i) push(K_IRV, 16'h0000, 2'b00, rd);
        if (prev_d) push(K_DRV, 16'h0000, 2'b00, rd);
        if (eig)    push(K_IG, ia, WE_RD, 16'h0000);
        if (edg)    push(K_DG, da, dwe, dwd);
        prev_i = eig;
        prev_d = edg && (dwe == WE_RD);
    endtask

    task automatic idle(input logic [15:0] rd);
        step(1'b0, 16'h0000, 1'b0, WE_RD, 16'h0000, 16'h0000, rd, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        logic [71:0] v;
        v = {i_gnt, d_gnt, i_rvalid, d_rvalid, m_en, m_we, i_rdata, d_rdata, m_addr, m_wdata};
        checks++;
        if (v != 72'h0) begin
            errors++;
            $display("FAIL %s: got outputs=%h, required all 0", name, v);
        end
    endtask

    initial begin
        rst = 1'b0;
        i_req = 1'b1; i_addr = 16'h1111; d_req = 1'b1; d_we = WE_RD;
        d_addr = 16'h2222; d_wdata = 16'h3333; m_rdata = 16'hFFFF;
        #3;
        check_zero("reset_state");
        @(negedge clk);
        i_req = 1'b0; d_req = 1'b0; m_rdata = 16'h0000;
        rst = 1'b1;
        idle(16'h0000);

        // Instruction read with one-cycle return.
        step(1'b1, 16'h0010, 1'b0, WE_RD, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        idle(16'hABCD);
        idle(16'h0000);

        // Simultaneous requests, word write wins and produces no rvalid.
        step(1'b1, 16'h0300, 1'b1, WE_WORD, 16'h0200, 16'h1234, 16'h0000, 1'b0, 1'b1);
        idle(16'h9999);
        // Byte-lane write.
        step(1'b0, 16'h0000, 1'b1, 2'b01, 16'h0042, 16'h00FF, 16'h0000, 1'b0, 1'b1);
        idle(16'h0000);

        // Data read then instruction read back-to-back.
        step(1'b0, 16'h0000, 1'b1, WE_RD, 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b1);
        step(1'b1, 16'h0020, 1'b0, WE_RD, 16'h0000, 16'h0000, 16'h5A5A, 1'b1, 1'b0);
        idle(16'h1111);
        idle(16'h0000);

        // Both ports requesting continuously.
        for (int k = 0; k < 20; k++) begin
`ifdef ARB_STARVE_EN
            step(1'b1, 16'h0030, 1'b1, WE_RD, 16'h0400 + 16'(k), 16'h0000, 16'hC000 + 16'(k),
                 (k % 5) == 4, (k % 5) != 4);
`else
            step(1'b1, 16'h0030, 1'b1, WE_RD, 16'h0400 + 16'(k), 16'h0000, 16'hC000 + 16'(k),
                 1'b0, 1'b1);
`endif
        end
        idle(16'hEEEE);
        idle(16'h0000);

        // Async reset right after a data read grant discards the pending rvalid.
        step(1'b0, 16'h0000, 1'b1, WE_RD, 16'h0500, 16'h0000, 16'h0000, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        m_rdata = 16'hBEEF;
        rst = 1'b0;
        prev_i = 1'b0;
        prev_d = 1'b0;
        #1;
        check_zero("async_reset_clear");
        @(negedge clk);
        d_req = 1'b0;
        @(posedge clk);
        #2;
        check_zero("reset_held");
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 16'h0055, 1'b0, WE_RD, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
        idle(16'h7777);
        idle(16'h0000);
        idle(16'h0000);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
